tl_inflight_checker: RTL and testbench

Sequential protocol-tracking stage for a TileLink-style A/D channel pair. It records every request issued on A by source ID and size, and counts beats on both channels. It then matches each D response beat against the recorded state. Each cycle it emits registered pass terms, and each term feeds one downstream assert stage together with `in_reset`; that stage prints and stops the simulation when all of its inputs are low.

---
 rtl/tl_inflight_checker_if.sv | 36 +++
 rtl/tl_inflight_checker.sv | 143 ++++++++++++++
 tb/tb_tl_inflight_checker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_inflight_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_checker_if
// Purpose  : Observation bundle for a TileLink-style A/D channel pair. It
//            carries the accepted-beat strobes plus the opcode, source and
//            size fields the in-flight checker tracks.
// Ports    : a_fire, a_has_data, a_source, a_size  - A channel beat info
//            d_fire, d_has_data, d_source, d_size  - D channel beat info
// Modports : master - drives the bundle (bus monitor / testbench)
//            slave  - observes the bundle (checker)
// Revision : 1.0 - initial release
// ============================================================================
interface tl_inflight_checker_if #(
   parameter int SOURCE_BITS = 4,
   parameter int SIZE_BITS   = 3
);
   logic                   a_fire;
   logic                   a_has_data;
   logic [SOURCE_BITS-1:0] a_source;
   logic [SIZE_BITS-1:0]   a_size;
   logic                   d_fire;
   logic                   d_has_data;
   logic [SOURCE_BITS-1:0] d_source;
   logic [SIZE_BITS-1:0]   d_size;

   modport master (
      output a_fire, a_has_data, a_source, a_size,
      output d_fire, d_has_data, d_source, d_size
   );

   modport slave (
      input a_fire, a_has_data, a_source, a_size,
      input d_fire, d_has_data, d_source, d_size
   );
endinterface
`default_nettype wire

// File: rtl/tl_inflight_checker.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_checker
// Purpose  : Tracks TileLink-style requests by source ID, counts beats on the
//            A and D channels and matches each D response against the state
//            recorded by its request. Produces registered pass terms for a
//            downstream assert stage. Observe-only: never stalls a channel.
// Ports    : clock, reset_n    - clock, async active-low reset
//            tl (slave)        - A/D channel beat observation bundle
//            ok_a_source       - first A beat used a source not in flight
//            ok_d_source       - D beat targeted an in-flight source
//            ok_d_size         - D size matched the recorded request size
//            in_reset          - reset plus one-cycle post-reset stretch
//            inflight_cnt      - number of sources currently in flight
// Revision : 1.0 - initial release
// ============================================================================
module tl_inflight_checker #(
   parameter int SOURCE_BITS = 4,
   parameter int SIZE_BITS   = 3,
   parameter int BEAT_LOG2   = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   tl_inflight_checker_if.slave tl,
   output logic                 ok_a_source,
   output logic                 ok_d_source,
   output logic                 ok_d_size,
   output logic                 in_reset,
   output logic [SOURCE_BITS:0] inflight_cnt
);
   localparam int NUM_SRC  = 1 << SOURCE_BITS;
   localparam int MAX_SIZE = (1 << SIZE_BITS) - 1;
   // Holds beats-1 for the largest burst with one bit of headroom.
   localparam int CNT_BITS = MAX_SIZE - BEAT_LOG2 + 1;
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   // Beats-1 of a message: multi-beat only when it carries data wider than
   // one bus beat.
   function automatic logic [CNT_BITS-1:0] beats_m1(
      input logic                 has_data,
      input logic [SIZE_BITS-1:0] size
   );
      logic [CNT_BITS-1:0] r;
      r = '0;
      if (has_data && (int'(size) > BEAT_LOG2))
         r = CNT_BITS'((1 << (int'(size) - BEAT_LOG2)) - 1);
      return r;
   endfunction

   logic [CNT_BITS-1:0]    a_cnt_q, a_cnt_d;
   logic [CNT_BITS-1:0]    d_cnt_q, d_cnt_d;
   logic [NUM_SRC-1:0]     inflight_q, inflight_d;
   logic [SIZE_BITS-1:0]   size_q [NUM_SRC];
   logic [SIZE_BITS-1:0]   size_d [NUM_SRC];
   logic [SOURCE_BITS:0]   cnt_q, cnt_d;
   logic                   ok_a_q, ok_a_d;
   logic                   ok_ds_q, ok_ds_d;
   logic                   ok_dz_q, ok_dz_d;
   logic                   stretch_q;
   logic                   in_reset_q;

   logic                   a_first;
   logic                   a_set;
   logic                   a_hit;
   logic                   d_last;
   logic                   d_hit;
   logic                   same_src_swap;

   always_comb begin
      // Beat counters: zero means the next beat opens a new message.
      a_first = (a_cnt_q == '0);
      a_cnt_d = a_cnt_q;
      if (tl.a_fire)
         a_cnt_d = a_first ? beats_m1(tl.a_has_data, tl.a_size) : (a_cnt_q - CNT_ONE);

      d_cnt_d = d_cnt_q;
      if (tl.d_fire)
         d_cnt_d = (d_cnt_q == '0) ? beats_m1(tl.d_has_data, tl.d_size) : (d_cnt_q - CNT_ONE);
      // The last D beat is the one that leaves the counter at zero.
      d_last = tl.d_fire && (d_cnt_d == '0);

      a_set         = tl.a_fire && a_first;
      a_hit         = inflight_q[tl.a_source];
      d_hit         = inflight_q[tl.d_source];
      same_src_swap = a_set && d_last && (tl.a_source == tl.d_source);

      // Clear before set so a same-source retire/reissue ends up in flight.
      inflight_d = inflight_q;
      size_d     = size_q;
      if (d_last)
         inflight_d[tl.d_source] = 1'b0;
      if (a_set) begin
         inflight_d[tl.a_source] = 1'b1;
         // A duplicate request keeps the original size unless the entry is
         // being retired on this same edge.
         if (!a_hit || same_src_swap)
            size_d[tl.a_source] = tl.a_size;
      end

      // All checks read the pre-update state.
      ok_a_d  = !(a_set && a_hit);
      ok_ds_d = !(tl.d_fire && !d_hit);
      ok_dz_d = !(tl.d_fire && d_hit && (tl.d_size != size_q[tl.d_source]));

      cnt_d = '0;
      for (int i = 0; i < NUM_SRC; i++)
         cnt_d = cnt_d + {{SOURCE_BITS{1'b0}}, inflight_d[i]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_cnt_q    <= '0;
         d_cnt_q    <= '0;
         inflight_q <= '0;
         size_q     <= '{default: '0};
         cnt_q      <= '0;
         ok_a_q     <= 1'b1;
         ok_ds_q    <= 1'b1;
         ok_dz_q    <= 1'b1;
         stretch_q  <= 1'b1;
         in_reset_q <= 1'b1;
      end else begin
         a_cnt_q    <= a_cnt_d;
         d_cnt_q    <= d_cnt_d;
         inflight_q <= inflight_d;
         size_q     <= size_d;
         cnt_q      <= cnt_d;
         ok_a_q     <= ok_a_d;
         ok_ds_q    <= ok_ds_d;
         ok_dz_q    <= ok_dz_d;
         // in_reset falls on the second edge after reset_n rises.
         stretch_q  <= 1'b0;
         in_reset_q <= stretch_q;
      end
   end

   assign ok_a_source  = ok_a_q  | in_reset_q;
   assign ok_d_source  = ok_ds_q | in_reset_q;
   assign ok_d_size    = ok_dz_q | in_reset_q;
   assign in_reset     = in_reset_q;
   assign inflight_cnt = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_tl_inflight_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_inflight_checker
// Purpose  : Directed self-checking bench for tl_inflight_checker. Each
//            stimulus cycle drives one beat at the falling edge; outputs are
//            compared 1 time unit after the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_inflight_checker;
   logic       clk;
   logic       reset_n;
   logic       ok_a_source;
   logic       ok_d_source;
   logic       ok_d_size;
   logic       in_reset;
   logic [4:0] inflight_cnt;

   int n_vec = 0;
   int n_err = 0;

   tl_inflight_checker_if #(.SOURCE_BITS(4), .SIZE_BITS(3)) tl_bus ();

   tl_inflight_checker #(
      .SOURCE_BITS (4),
      .SIZE_BITS   (3),
      .BEAT_LOG2   (2)
   ) u_dut (
      .clock        (clk),
      .reset_n      (reset_n),
      .tl           (tl_bus),
      .ok_a_source  (ok_a_source),
      .ok_d_source  (ok_d_source),
      .ok_d_size    (ok_d_size),
      .in_reset     (in_reset),
      .inflight_cnt (inflight_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic a, input logic ds,
                            input logic dz, input logic [4:0] cnt);
      check_eq({tag, ".ok_a_source"}, 32'(ok_a_source), 32'(a));
      check_eq({tag, ".ok_d_source"}, 32'(ok_d_source), 32'(ds));
      check_eq({tag, ".ok_d_size"},   32'(ok_d_size),   32'(dz));
      check_eq({tag, ".inflight_cnt"}, 32'(inflight_cnt), 32'(cnt));
   endtask

   // One beat on A and/or D, presented for exactly one rising edge.
   task automatic cycle(input logic af, input logic ahd, input logic [3:0] as_, input logic [2:0] asz,
                        input logic df, input logic dhd, input logic [3:0] ds_, input logic [2:0] dsz);
      @(negedge clk);
      tl_bus.a_fire     = af;
      tl_bus.a_has_data = ahd;
      tl_bus.a_source   = as_;
      tl_bus.a_size     = asz;
      tl_bus.d_fire     = df;
      tl_bus.d_has_data = dhd;
      tl_bus.d_source   = ds_;
      tl_bus.d_size     = dsz;
      @(posedge clk);
      #1;
      tl_bus.a_fire = 1'b0;
      tl_bus.d_fire = 1'b0;
   endtask

   task automatic a_only(input logic hd, input logic [3:0] src, input logic [2:0] sz);
      cycle(1'b1, hd, src, sz, 1'b0, 1'b0, 4'd0, 3'd0);
   endtask

   task automatic d_only(input logic hd, input logic [3:0] src, input logic [2:0] sz);
      cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b1, hd, src, sz);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tl_bus.a_fire = 1'b0; tl_bus.a_has_data = 1'b0; tl_bus.a_source = '0; tl_bus.a_size = '0;
      tl_bus.d_fire = 1'b0; tl_bus.d_has_data = 1'b0; tl_bus.d_source = '0; tl_bus.d_size = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1'b1, 1'b1, 1'b1, 5'd0);
      check_eq("reset.in_reset", 32'(in_reset), 32'd1);

      // in_reset holds through the first edge after release, drops on the second.
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post1.in_reset", 32'(in_reset), 32'd1);
      @(posedge clk); #1;
      check_eq("post2.in_reset", 32'(in_reset), 32'd0);
      for (int i = 0; i < 8; i++) idle();
      check_all("idle", 1'b1, 1'b1, 1'b1, 5'd0);

      // Get src3 size2 then single-beat AccessAckData.
      a_only(1'b0, 4'd3, 3'd2);
      check_all("get3", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b1, 4'd3, 3'd2);
      check_all("ack3", 1'b1, 1'b1, 1'b1, 5'd0);

      // Put src5 size4: four A beats, one entry; AccessAck clears it.
      for (int i = 0; i < 4; i++) begin
         a_only(1'b1, 4'd5, 3'd4);
         check_all($sformatf("put5.b%0d", i), 1'b1, 1'b1, 1'b1, 5'd1);
      end
      d_only(1'b0, 4'd5, 3'd4);
      check_all("ack5", 1'b1, 1'b1, 1'b1, 5'd0);

      // Duplicate Get src2: flagged for exactly one cycle, size kept at 2.
      a_only(1'b0, 4'd2, 3'd2);
      check_all("get2a", 1'b1, 1'b1, 1'b1, 5'd1);
      a_only(1'b0, 4'd2, 3'd3);
      check_all("get2b", 1'b0, 1'b1, 1'b1, 5'd1);
      idle();
      check_all("get2.idle", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b1, 4'd2, 3'd2);
      check_all("ack2", 1'b1, 1'b1, 1'b1, 5'd0);

      // Response to a source never requested.
      d_only(1'b0, 4'd7, 3'd2);
      check_all("d7.stray", 1'b1, 1'b0, 1'b1, 5'd0);
      idle();
      check_all("d7.idle", 1'b1, 1'b1, 1'b1, 5'd0);

      // Size mismatch: recorded 2, response says 3.
      a_only(1'b0, 4'd3, 3'd2);
      check_all("get3s", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b0, 4'd3, 3'd3);
      check_all("ack3.badsize", 1'b1, 1'b1, 1'b0, 5'd0);

      // Same-cycle retire and reissue of src1. The A check sees src1 still in
      // flight (pre-update state); the entry survives with the new size 3.
      a_only(1'b0, 4'd1, 3'd2);
      check_all("get1", 1'b1, 1'b1, 1'b1, 5'd1);
      cycle(1'b1, 1'b0, 4'd1, 3'd3, 1'b1, 1'b1, 4'd1, 3'd2);
      check_all("swap1", 1'b0, 1'b1, 1'b1, 5'd1);
      d_only(1'b0, 4'd1, 3'd3);
      check_all("ack1.newsize", 1'b1, 1'b1, 1'b1, 5'd0);

      // +1 and -1 on different sources in one cycle.
      a_only(1'b0, 4'd6, 3'd2);
      check_all("get6", 1'b1, 1'b1, 1'b1, 5'd1);
      cycle(1'b1, 1'b0, 4'd9, 3'd2, 1'b1, 1'b0, 4'd6, 3'd2);
      check_all("get9.ack6", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b0, 4'd9, 3'd2);
      check_all("ack9", 1'b1, 1'b1, 1'b1, 5'd0);

      // Eight-beat AccessAckData: only the eighth beat retires the entry.
      a_only(1'b0, 4'd0, 3'd5);
      for (int i = 0; i < 7; i++) d_only(1'b1, 4'd0, 3'd5);
      check_all("ack0.b7", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b1, 4'd0, 3'd5);
      check_all("ack0.b8", 1'b1, 1'b1, 1'b1, 5'd0);

      // Largest burst: 32-beat Put, then a new request must be a first beat.
      for (int i = 0; i < 32; i++) a_only(1'b1, 4'd15, 3'd7);
      check_all("put15.b32", 1'b1, 1'b1, 1'b1, 5'd1);
      a_only(1'b0, 4'd14, 3'd2);
      check_all("get14", 1'b1, 1'b1, 1'b1, 5'd2);
      d_only(1'b0, 4'd15, 3'd7);
      check_all("ack15", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b0, 4'd14, 3'd2);
      check_all("ack14", 1'b1, 1'b1, 1'b1, 5'd0);

      // Reset in the middle of a Put burst clears everything at once.
      a_only(1'b1, 4'd5, 3'd4);
      a_only(1'b1, 4'd5, 3'd4);
      check_all("midput", 1'b1, 1'b1, 1'b1, 5'd1);
      #2 reset_n = 1'b0;
      #1;
      check_all("midrst", 1'b1, 1'b1, 1'b1, 5'd0);
      check_eq("midrst.in_reset", 32'(in_reset), 32'd1);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("midrst.released", 32'(in_reset), 32'd0);
      d_only(1'b0, 4'd5, 3'd4);
      check_all("midrst.stray", 1'b1, 1'b0, 1'b1, 5'd0);
      // A beat counter was cleared too, so this is a first beat.
      a_only(1'b0, 4'd5, 3'd2);
      check_all("midrst.get5", 1'b1, 1'b1, 1'b1, 5'd1);
      d_only(1'b0, 4'd5, 3'd2);
      check_all("midrst.ack5", 1'b1, 1'b1, 1'b1, 5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
